pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 111 +++++++++++
 tb/tb_pipe_stage_skid.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with a one-entry skid buffer.
// Ports: CLK/nRST, in_valid/in_ready/in_data, flush, out_valid/out_ready/out_data, bubble_cnt.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int unsigned      CNTW      = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_skid_d;
  logic [CNTW-1:0]  r_cnt;
  logic             w_acc;
  logic             w_send;

  assign w_acc  = in_valid & in_ready;
  assign w_send = out_valid & out_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_EMPTY;
      r_main  <= NOP_VALUE;
      r_skid  <= NOP_VALUE;
    end else begin
      r_state <= w_next;
      r_main  <= w_main_d;
      r_skid  <= w_skid_d;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_main_d = r_main;
    w_skid_d = r_skid;
    unique case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_next   = S_ONE;
          w_main_d = in_data;
        end
      end
      S_ONE: begin
        if (w_acc && w_send) begin
          w_main_d = in_data;
        end else if (w_acc) begin
          w_next   = S_FULL;
          w_skid_d = in_data;
        end else if (w_send) begin
          w_next   = S_EMPTY;
          w_main_d = NOP_VALUE;
        end
      end
      S_FULL: begin
        if (w_send) begin
          w_next   = S_ONE;
          w_main_d = r_skid;
          w_skid_d = NOP_VALUE;
        end
      end
      default: begin
        w_next   = S_EMPTY;
        w_main_d = NOP_VALUE;
        w_skid_d = NOP_VALUE;
      end
    endcase
    // flush wins over every transition; a same-cycle accept is dropped
    if (flush) begin
      w_next   = S_EMPTY;
      w_main_d = NOP_VALUE;
      w_skid_d = NOP_VALUE;
    end
  end

  always_comb begin
    in_ready  = (r_state == S_EMPTY) || (r_state == S_ONE);
    out_valid = (r_state == S_ONE) || (r_state == S_FULL);
    out_data  = out_valid ? r_main : NOP_VALUE;
  end

  // counts idle-downstream cycles, saturating, untouched by flush
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (out_ready && !out_valid && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign bubble_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed vector bench for pipe_stage_skid.
// Table-driven streaming/backpressure/flush plus saturation and async reset sequences.
module tb_pipe_stage_skid;

  localparam logic [31:0] NOP = 32'hDEAD_BEEF;

  logic        CLK;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] bubble_cnt;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_data;
  logic        s_flush;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_out_data;
  logic [3:0]  s_bubble_cnt;

  int errors;
  int checks;

  pipe_stage_skid #(
    .WIDTH(32),
    .NOP_VALUE(NOP),
    .CNTW(16)
  ) u_dut (
    .CLK(CLK),
    .nRST(nRST),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(
    .WIDTH(8),
    .CNTW(4)
  ) u_sat (
    .CLK(CLK),
    .nRST(nRST),
    .in_valid(s_in_valid),
    .in_ready(s_in_ready),
    .in_data(s_in_data),
    .flush(s_flush),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_data(s_out_data),
    .bubble_cnt(s_bubble_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic [31:0] eod;
    logic        eir;
    logic [15:0] ebub;
  } vec_t;

  vec_t tv[20];

  function automatic vec_t mk(
    input logic iv, input logic [31:0] d,
    input logic ordy, input logic fl,
    input logic eov, input logic [31:0] eod,
    input logic eir, input logic [15:0] ebub
  );
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.eov = eov; v.eod = eod; v.eir = eir; v.ebub = ebub;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    nRST = 1'b0;
    in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_flush = 1'b0; s_out_ready = 1'b0;

    // streaming
    tv[0]  = mk(1, 32'h1,  1, 0, 1, 32'h1,  1, 16'd1);
    tv[1]  = mk(1, 32'h2,  1, 0, 1, 32'h2,  1, 16'd1);
    tv[2]  = mk(1, 32'h3,  1, 0, 1, 32'h3,  1, 16'd1);
    tv[3]  = mk(1, 32'h4,  1, 0, 1, 32'h4,  1, 16'd1);
    tv[4]  = mk(0, 32'h0,  1, 0, 0, NOP,    1, 16'd1);
    tv[5]  = mk(0, 32'h0,  1, 0, 0, NOP,    1, 16'd2);
    // backpressure into skid
    tv[6]  = mk(1, 32'hA,  0, 0, 1, 32'hA,  1, 16'd2);
    tv[7]  = mk(1, 32'hB,  0, 0, 1, 32'hA,  0, 16'd2);
    tv[8]  = mk(1, 32'hC,  0, 0, 1, 32'hA,  0, 16'd2);
    tv[9]  = mk(1, 32'hC,  1, 0, 1, 32'hB,  1, 16'd2);
    tv[10] = mk(1, 32'hC,  1, 0, 1, 32'hC,  1, 16'd2);
    tv[11] = mk(0, 32'h0,  1, 0, 0, NOP,    1, 16'd2);
    // flush in FULL, then flush with send / flush while empty
    tv[12] = mk(1, 32'h11, 0, 0, 1, 32'h11, 1, 16'd2);
    tv[13] = mk(1, 32'h22, 0, 0, 1, 32'h11, 0, 16'd2);
    tv[14] = mk(1, 32'h33, 0, 1, 0, NOP,    1, 16'd2);
    tv[15] = mk(0, 32'h0,  0, 0, 0, NOP,    1, 16'd2);
    tv[16] = mk(1, 32'h44, 1, 0, 1, 32'h44, 1, 16'd3);
    tv[17] = mk(1, 32'h55, 1, 1, 0, NOP,    1, 16'd3);
    tv[18] = mk(1, 32'h66, 1, 1, 0, NOP,    1, 16'd4);
    tv[19] = mk(0, 32'h0,  1, 0, 0, NOP,    1, 16'd5);

    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, NOP);
    chk("rst_bubble", {16'd0, bubble_cnt}, 32'd0);
    tick();
    nRST = 1'b1;

    for (int i = 0; i < 20; i++) begin
      in_valid  = tv[i].iv;
      in_data   = tv[i].d;
      out_ready = tv[i].ordy;
      flush     = tv[i].fl;
      tick();
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].eov});
      chk($sformatf("v%0d_out_data", i), out_data, tv[i].eod);
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].eir});
      chk($sformatf("v%0d_bubble", i), {16'd0, bubble_cnt}, {16'd0, tv[i].ebub});
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // bubble saturation on the 4-bit counter
    s_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("sat_c%0d", i), {28'd0, s_bubble_cnt},
          (i < 15) ? (i + 1) : 15);
    end
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    chk("sat_flush", {28'd0, s_bubble_cnt}, 32'd15);
    chk("sat_flush_ov", {31'd0, s_out_valid}, 32'd0);
    tick();
    chk("sat_hold", {28'd0, s_bubble_cnt}, 32'd15);

    // async reset while FULL
    in_valid = 1'b1; in_data = 32'h71; out_ready = 1'b0;
    tick();
    in_data = 32'h72;
    tick();
    chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", out_data, NOP);
    chk("arst_bubble", {16'd0, bubble_cnt}, 32'd0);
    tick();
    nRST = 1'b1;
    in_valid = 1'b1; in_data = 32'h5A; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_ov", {31'd0, out_valid}, 32'd1);
    chk("post_rst_od", out_data, 32'h5A);
    tick();
    chk("post_rst_drain", {31'd0, out_valid}, 32'd0);
    chk("post_rst_nop", out_data, NOP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
